// File: rtl/chain_pkg.sv
// -----------------------------------------------------------------------------
// chain_pkg
// Shared constants and types for the seed-chaining DP scheduler.
//   AW        : default anchor coordinate width
//   SW        : default signed chain-score width
//   PRED_NONE : predecessor index meaning "no predecessor" (all ones)
//   state_t   : scheduler FSM states
// -----------------------------------------------------------------------------
package chain_pkg;

  localparam int AW = 32;
  localparam int SW = 32;

  localparam logic [31:0] PRED_NONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/chain_anchor_buf.sv
// -----------------------------------------------------------------------------
// chain_anchor_buf
// N_PRED-deep ring of previously scored anchors {rx, qy, f}.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_wr_en               : push {i_wr_rx, i_wr_qy, i_wr_f} at the write pointer
//   i_clr                 : empty the ring (end of read); wins over the count
//                           update of a simultaneous push
//   i_rd_off              : read offset, 0 = newest entry
//   o_rd_rx/qy/f          : combinational read data at i_rd_off
//   o_count               : valid entries, saturates at N_PRED
// -----------------------------------------------------------------------------
module chain_anchor_buf #(
  parameter int N_PRED = 16,
  parameter int AW     = 32,
  parameter int SW     = 32,
  localparam int OW    = $clog2(N_PRED)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_en,
  input  logic                 i_clr,
  input  logic [AW-1:0]        i_wr_rx,
  input  logic [AW-1:0]        i_wr_qy,
  input  logic signed [SW-1:0] i_wr_f,
  input  logic [OW-1:0]        i_rd_off,
  output logic [AW-1:0]        o_rd_rx,
  output logic [AW-1:0]        o_rd_qy,
  output logic signed [SW-1:0] o_rd_f,
  output logic [OW:0]          o_count
);

  logic [AW-1:0]        r_mem_rx [N_PRED];
  logic [AW-1:0]        r_mem_qy [N_PRED];
  logic signed [SW-1:0] r_mem_f  [N_PRED];
  logic [OW-1:0]        r_wr_ptr;
  logic [OW:0]          r_count;
  logic [OW-1:0]        w_rd_idx;

  // Entry contents need no reset: r_count gates which entries are meaningful.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem_rx[r_wr_ptr] <= i_wr_rx;
      r_mem_qy[r_wr_ptr] <= i_wr_qy;
      r_mem_f[r_wr_ptr]  <= i_wr_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_wr_en) begin
      r_wr_ptr <= r_wr_ptr + OW'(1);
      if (r_count != (OW+1)'(N_PRED)) begin
        r_count <= r_count + (OW+1)'(1);
      end
    end
  end

  // Newest entry sits just behind the write pointer; power-of-2 depth wraps.
  assign w_rd_idx = r_wr_ptr - OW'(1) - i_rd_off;
  assign o_rd_rx  = r_mem_rx[w_rd_idx];
  assign o_rd_qy  = r_mem_qy[w_rd_idx];
  assign o_rd_f   = r_mem_f[w_rd_idx];
  assign o_count  = r_count;

endmodule

// File: rtl/chain_dp_sched.sv
// -----------------------------------------------------------------------------
// chain_dp_sched
// Sequences the combinational chaining-score datapath. Each accepted anchor i
// is compared against up to N_PRED buffered predecessors, newest first, one
// per cycle; f[i] = max(W, f[j] + score) is emitted with its predecessor.
// Optional macro CHAIN_BAND_EN adds cfg_band and a diagonal band filter.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   in_valid/in_ready, in_rx/qy/last : anchor input handshake
//   cfg_w, cfg_w_avg, cfg_max_dist : seed weight, avg weight, max ref gap
//   cfg_band (CHAIN_BAND_EN only)  : max |diagonal difference|
//   sc_rix/riy/qix/qiy, sc_w/w_avg : operands to the score datapath
//   sc_result                      : datapath score (signed, combinational)
//   out_valid/out_ready, out_idx/score/pred : result handshake
// -----------------------------------------------------------------------------
module chain_dp_sched
  import chain_pkg::*;
#(
  parameter int N_PRED = 16,
  parameter int AW     = chain_pkg::AW,
  parameter int SW     = chain_pkg::SW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        in_rx,
  input  logic [AW-1:0]        in_qy,
  input  logic                 in_last,
  input  logic [31:0]          cfg_w,
  input  logic [31:0]          cfg_w_avg,
  input  logic [AW-1:0]        cfg_max_dist,
`ifdef CHAIN_BAND_EN
  input  logic [AW-1:0]        cfg_band,
`endif
  output logic [AW-1:0]        sc_rix,
  output logic [AW-1:0]        sc_riy,
  output logic [AW-1:0]        sc_qix,
  output logic [AW-1:0]        sc_qiy,
  output logic [31:0]          sc_w,
  output logic [31:0]          sc_w_avg,
  input  logic signed [SW-1:0] sc_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_idx,
  output logic signed [SW-1:0] out_score,
  output logic [31:0]          out_pred
);

  localparam int OW = $clog2(N_PRED);

  state_t               r_state, w_state_next;
  logic [AW-1:0]        r_rx_i, r_qy_i;
  logic                 r_last;
  logic signed [SW-1:0] r_best;
  logic [31:0]          r_pred, r_idx;
  logic [OW-1:0]        r_off;

  logic [AW-1:0]        w_rd_rx, w_rd_qy;
  logic signed [SW-1:0] w_rd_f;
  logic [OW:0]          w_count;

  logic                 w_accept, w_update, w_emit_done;
  logic [AW:0]          w_gap;
  logic                 w_stop, w_skip, w_off_band, w_better, w_last_entry;
  logic signed [SW:0]   w_sum;
  logic signed [SW-1:0] w_cand;

  chain_anchor_buf #(.N_PRED(N_PRED), .AW(AW), .SW(SW)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_emit_done),
    .i_clr    (w_emit_done & r_last),
    .i_wr_rx  (r_rx_i),
    .i_wr_qy  (r_qy_i),
    .i_wr_f   (r_best),
    .i_rd_off (r_off),
    .o_rd_rx  (w_rd_rx),
    .o_rd_qy  (w_rd_qy),
    .o_rd_f   (w_rd_f),
    .o_count  (w_count)
  );

  // Gap kept one bit wider so a (never expected) rx_j > rx_i cannot alias
  // into a huge positive gap and stop the scan.
  assign w_gap        = {1'b0, r_rx_i} - {1'b0, w_rd_rx};
  assign w_stop       = !w_gap[AW] && (w_gap[AW-1:0] > cfg_max_dist);
  assign w_skip       = (w_rd_rx >= r_rx_i) || (w_rd_qy >= r_qy_i);
  assign w_last_entry = ({1'b0, r_off} == (w_count - (OW+1)'(1)));

`ifdef CHAIN_BAND_EN
  logic [AW:0]   w_dq;
  logic [AW+1:0] w_diag, w_diag_abs;
  assign w_dq       = {1'b0, r_qy_i} - {1'b0, w_rd_qy};
  assign w_diag     = {w_gap[AW], w_gap} - {w_dq[AW], w_dq};
  assign w_diag_abs = w_diag[AW+1] ? (~w_diag + (AW+2)'(1)) : w_diag;
  assign w_off_band = w_diag_abs > {2'b00, cfg_band};
`else
  assign w_off_band = 1'b0;
`endif

  // f[j] + score in SW+1 bits, clamped back into the signed SW range.
  assign w_sum = {w_rd_f[SW-1], w_rd_f} + {sc_result[SW-1], sc_result};
  always_comb begin
    w_cand = w_sum[SW-1:0];
    if (w_sum[SW] != w_sum[SW-1]) begin
      w_cand = w_sum[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
    end
  end
  // Strict compare: on ties the nearer (earlier scanned) predecessor stays.
  assign w_better = w_cand > r_best;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_update     = 1'b0;
    w_emit_done  = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = (w_count == '0) ? EMIT : SCAN;
        end
      end
      SCAN: begin
        if (w_stop) begin
          w_state_next = EMIT;
        end else begin
          w_update = !w_skip && !w_off_band && w_better;
          if (w_last_entry) w_state_next = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_emit_done  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_i <= '0;
      r_qy_i <= '0;
      r_last <= 1'b0;
      r_best <= '0;
      r_pred <= '0;
      r_idx  <= '0;
      r_off  <= '0;
    end else begin
      if (w_accept) begin
        r_rx_i <= in_rx;
        r_qy_i <= in_qy;
        r_last <= in_last;
        r_best <= SW'($signed(cfg_w));
        r_pred <= PRED_NONE;
        r_off  <= '0;
      end else if (r_state == SCAN) begin
        if (w_update) begin
          r_best <= w_cand;
          r_pred <= r_idx - 32'd1 - 32'(r_off);
        end
        r_off <= r_off + OW'(1);
      end
      if (w_emit_done) begin
        r_idx <= r_last ? 32'd0 : r_idx + 32'd1;
      end
    end
  end

  assign sc_rix    = (r_state == SCAN) ? r_rx_i  : '0;
  assign sc_riy    = (r_state == SCAN) ? w_rd_rx : '0;
  assign sc_qix    = (r_state == SCAN) ? r_qy_i  : '0;
  assign sc_qiy    = (r_state == SCAN) ? w_rd_qy : '0;
  assign sc_w      = cfg_w;
  assign sc_w_avg  = cfg_w_avg;
  assign out_idx   = r_idx;
  assign out_score = r_best;
  assign out_pred  = r_pred;

endmodule

// File: tb/tb_chain_dp_sched.sv
// -----------------------------------------------------------------------------
// tb_chain_dp_sched
// Directed and randomized anchors against a queue-based reference model of
// the chaining recurrence. The score datapath is stubbed by score_fn.
// -----------------------------------------------------------------------------
module tb_chain_dp_sched;
  import chain_pkg::*;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0] in_rx = '0, in_qy = '0;
  logic [31:0] cfg_w = 32'd15, cfg_w_avg = 32'd7, cfg_max_dist = 32'd1000;
  logic [31:0] cfg_band = 32'd1000;
  wire         in_ready, out_valid;
  wire  [31:0] sc_rix, sc_riy, sc_qix, sc_qiy, sc_w, sc_w_avg;
  wire  [31:0] out_idx, out_pred;
  wire  signed [31:0] out_score;
  logic signed [31:0] sc_result;

  int                 sc_mode = 0;
  logic signed [31:0] sc_base = 32'sd8;

  int checks = 0;
  int errors = 0;

  // Current-read history of the model: coordinates and scores per anchor.
  longint m_rx[$], m_qy[$], m_f[$];

  chain_dp_sched #(.N_PRED(NP), .AW(32), .SW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rx        (in_rx),
    .in_qy        (in_qy),
    .in_last      (in_last),
    .cfg_w        (cfg_w),
    .cfg_w_avg    (cfg_w_avg),
    .cfg_max_dist (cfg_max_dist),
`ifdef CHAIN_BAND_EN
    .cfg_band     (cfg_band),
`endif
    .sc_rix       (sc_rix),
    .sc_riy       (sc_riy),
    .sc_qix       (sc_qix),
    .sc_qiy       (sc_qiy),
    .sc_w         (sc_w),
    .sc_w_avg     (sc_w_avg),
    .sc_result    (sc_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_score    (out_score),
    .out_pred     (out_pred)
  );

  // Mode 0: constant score. Mode 1: score depends on the operand geometry,
  // so mis-wired operands change the result.
  function automatic logic signed [31:0] score_fn(input int mode, input logic signed [31:0] base,
                                                  input logic [31:0] rxi, rxj, qyi, qyj);
    logic [31:0] dr, dq;
    dr = rxi - rxj;
    dq = qyi - qyj;
    if (mode == 0) return base;
    return base + $signed({29'd0, dr[2:0]}) - $signed({30'd0, dq[1:0]});
  endfunction

  assign sc_result = score_fn(sc_mode, sc_base, sc_rix, sc_riy, sc_qix, sc_qiy);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected result of offering (rx, qy) now, from the recurrence itself.
  task automatic model(input longint rx, input longint qy,
                       output logic [31:0] e_idx, output logic [31:0] e_pred,
                       output logic [31:0] e_score, output int e_lat);
    longint best, cand;
    int pred, k, n;
    best = longint'($signed(cfg_w));
    pred = -1;
    k    = 0;
    n    = m_rx.size();
    for (int j = n - 1; j >= 0 && j >= n - NP; j--) begin
      k++;
      if (rx - m_rx[j] > longint'(cfg_max_dist)) break;
      if (m_rx[j] >= rx || m_qy[j] >= qy) continue;
`ifdef CHAIN_BAND_EN
      begin
        longint d;
        d = (rx - m_rx[j]) - (qy - m_qy[j]);
        if (d < 0) d = -d;
        if (d > longint'(cfg_band)) continue;
      end
`endif
      cand = m_f[j] + longint'(score_fn(sc_mode, sc_base, 32'(rx), 32'(m_rx[j]),
                                        32'(qy), 32'(m_qy[j])));
      if (cand > 64'sd2147483647) cand = 64'sd2147483647;
      if (cand < -64'sd2147483648) cand = -64'sd2147483648;
      if (cand > best) begin
        best = cand;
        pred = j;
      end
    end
    e_idx   = 32'(n);
    e_pred  = (pred < 0) ? PRED_NONE : 32'(pred);
    e_score = 32'(best);
    e_lat   = 1 + k;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_rx.delete(); m_qy.delete(); m_f.delete();
    @(negedge clk);
  endtask

  // One full anchor transaction: offer, measure latency, hold, drain.
  task automatic anchor(input logic [31:0] rx, input logic [31:0] qy, input logic last,
                        input int hold, input string tag);
    logic [31:0] e_idx, e_pred, e_score;
    int e_lat, n, lat;
    model(longint'(rx), longint'(qy), e_idx, e_pred, e_score, e_lat);
    @(negedge clk);
    in_rx = rx; in_qy = qy; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    check({tag, " latency"}, 32'(lat), 32'(e_lat));
    check({tag, " out_idx"}, out_idx, e_idx);
    check({tag, " out_score"}, out_score, e_score);
    check({tag, " out_pred"}, out_pred, e_pred);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " hold out_idx"}, out_idx, e_idx);
      check({tag, " hold out_score"}, out_score, e_score);
      check({tag, " hold out_pred"}, out_pred, e_pred);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " drained"}, 32'(out_valid), 32'd0);
    $display("anchor %-10s rx=%0d qy=%0d last=%0d -> idx=%0d score=%0d pred=0x%0h lat=%0d",
             tag, rx, qy, last, out_idx === e_idx ? e_idx : out_idx, $signed(e_score), e_pred, lat);
    m_rx.push_back(longint'(rx));
    m_qy.push_back(longint'(qy));
    m_f.push_back(longint'($signed(e_score)));
    if (last) begin
      m_rx.delete(); m_qy.delete(); m_f.delete();
    end
  endtask

  initial begin
    logic [31:0] rx, qy;
    int len;

    // Reset state
    do_reset();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_score", out_score, 32'd0);
    check("rst out_idx", out_idx, 32'd0);
    check("rst out_pred", out_pred, 32'd0);
    check("rst sc_rix", sc_rix, 32'd0);
    check("rst sc_w", sc_w, 32'd15);
    check("rst sc_w_avg", sc_w_avg, 32'd7);

    // Single anchor: no predecessors
    anchor(32'd100, 32'd50, 1'b1, 0, "single");

    // Three-anchor chain, constant score 8
    sc_base = 32'sd8;
    anchor(32'd100, 32'd50, 1'b0, 0, "chain0");
    anchor(32'd120, 32'd70, 1'b0, 0, "chain1");
    anchor(32'd140, 32'd90, 1'b1, 0, "chain2");
    anchor(32'd500, 32'd500, 1'b1, 0, "newread");

    // Skip on equal rx, then on non-increasing qy
    anchor(32'd100, 32'd50, 1'b0, 0, "eqrx0");
    anchor(32'd100, 32'd60, 1'b1, 0, "eqrx1");
    anchor(32'd100, 32'd50, 1'b0, 0, "qy0");
    anchor(32'd110, 32'd40, 1'b1, 0, "qy1");

    // Max-distance stop
    cfg_max_dist = 32'd30;
    anchor(32'd0, 32'd0, 1'b0, 0, "dist0");
    anchor(32'd10, 32'd10, 1'b0, 0, "dist1");
    anchor(32'd50, 32'd50, 1'b1, 0, "dist2");
    cfg_max_dist = 32'd1000;

    // Window limited to NP entries; backpressure on anchor 5
    sc_base = 32'sd1;
    for (int a = 0; a < 6; a++) begin
      anchor(32'(100 + 10 * a), 32'(50 + 10 * a), a == 5, (a == 5) ? 5 : 0, "window");
    end

    // Reset asserted mid-scan
    sc_base = 32'sd8;
    anchor(32'd100, 32'd50, 1'b0, 0, "pre_rst");
    @(negedge clk);
    in_rx = 32'd120; in_qy = 32'd70; in_last = 1'b0; in_valid = 1'b1;
    check("midscan in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("midscan sc_rix", sc_rix, 32'd120);
    check("midscan sc_riy", sc_riy, 32'd100);
    check("midscan sc_qix", sc_qix, 32'd70);
    check("midscan sc_qiy", sc_qiy, 32'd50);
    rst_n = 1'b0;
    @(negedge clk);
    check("midscan rst out_valid", 32'(out_valid), 32'd0);
    check("midscan rst in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    m_rx.delete(); m_qy.delete(); m_f.delete();
    anchor(32'd300, 32'd300, 1'b1, 0, "post_rst");

    // Positive saturation, ties keep the nearer predecessor
    cfg_w = 32'h7FFF_FFF0; sc_base = 32'sd100;
    anchor(32'd100, 32'd50, 1'b0, 0, "satp0");
    anchor(32'd120, 32'd70, 1'b0, 0, "satp1");
    anchor(32'd140, 32'd90, 1'b1, 0, "satp2");

    // Negative saturation must not wrap to a large positive score
    cfg_w = 32'h8000_0010; sc_base = -32'sd100;
    anchor(32'd100, 32'd50, 1'b0, 0, "satn0");
    anchor(32'd120, 32'd70, 1'b1, 0, "satn1");

    // Randomized reads with geometry-dependent scores
    sc_mode = 1;
    for (int r = 0; r < 10; r++) begin
      cfg_w        = 32'($urandom_range(0, 30));
      sc_base      = $signed(32'($urandom_range(0, 25))) - 32'sd5;
      cfg_max_dist = 32'($urandom_range(20, 120));
      len = int'($urandom_range(1, 7));
      rx  = 32'($urandom_range(0, 100));
      qy  = 32'($urandom_range(10, 100));
      for (int a = 0; a < len; a++) begin
        rx = rx + 32'($urandom_range(0, 25));
        qy = qy + 32'($urandom_range(0, 25)) - 32'd5;
        anchor(rx, qy, a == len - 1, int'($urandom_range(0, 1)), "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
